// File: rtl/pipe_regfile.sv
// Register file with one write port, two write-first bypassed read ports and a
// per-register busy scoreboard for read-after-write hazard detection in decode.
module pipe_regfile #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int ZERO_REG0 = 0,
  localparam int DEPTH    = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_ok;
  logic              iss_ok;
  logic              byp_a;
  logic              byp_b;
  logic              zero_a;
  logic              zero_b;

  // With a hardwired R0, writes and reservations aimed at index 0 vanish here,
  // so neither the array, the bypass nor the scoreboard ever sees them.
  assign wr_ok  = wr_en  & ~((ZERO_REG0 != 0) && (wr_addr  == '0));
  assign iss_ok = iss_en & ~((ZERO_REG0 != 0) && (iss_addr == '0));

  assign byp_a  = wr_ok && (wr_addr == rd_addr_a);
  assign byp_b  = wr_ok && (wr_addr == rd_addr_b);
  assign zero_a = (ZERO_REG0 != 0) && (rd_addr_a == '0);
  assign zero_b = (ZERO_REG0 != 0) && (rd_addr_b == '0);

  // Clear before set, so a new producer issued in the same cycle keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wr_addr]  = 1'b0;
    if (iss_ok) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) regs_q[wr_addr] <= wr_data;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if (zero_a) rd_data_a = '0;
    if (byp_a)  rd_data_a = wr_data;
    rd_data_b = regs_q[rd_addr_b];
    if (zero_b) rd_data_b = '0;
    if (byp_b)  rd_data_b = wr_data;
  end

  // A bypassed operand is final, so it is never reported busy.
  assign busy_a   = busy_q[rd_addr_a] & ~byp_a;
  assign busy_b   = busy_q[rd_addr_b] & ~byp_b;
  assign busy_vec = busy_q;

endmodule
